exmem_div_unit: RTL and testbench
=================================

# exmem_div_unit

Iterative unsigned vector divide/modulo unit for the EX/MEM stage of the cardinal CMP core. It executes VDIV/VMOD-class instructions issued from the ID/EX-MEM pipeline register at one quotient bit per cycle, with lanes selected by WW. While busy it drives `stall` back to the ID/EX-MEM register and the upstream stages, and presents the lane-packed result to write-back with the captured destination fields.

## Interface
- No parameters. Datapath is fixed at 64 bits; bit 0 is the MSB (`[0:63]` ordering).
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: a divide-class instruction is present in EX/MEM. The ID/EX-MEM register holds it for as long as `stall` is high.
- `op_mod` in 1: 0 returns quotients, 1 returns remainders.
- `ww` in 2: lane width. 00 = 8×8b, 01 = 4×16b, 10 = 2×32b, 11 = 1×64b.
- `a_data` in 64: dividend lanes; lane 0 occupies the MS bits.
- `b_data` in 64: divisor lanes.
- `rd_in` in 5, `ppp_in` in 3: destination register and participation field, captured at start.
- `stall` out 1: freeze request to upstream stages.
- `result` out 64: packed quotient or remainder.
- `result_valid` out 1: one-cycle pulse when `result` is valid.
- `rd_out` out 5, `ppp_out` out 3, `ww_out` out 2: captured fields, valid alongside `result`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE, `start`=1:**
  - Latch `a_data`, `b_data`, `op_mod`, `ww`, `rd_in` and `ppp_in`.
  - Clear the 6-bit iteration counter `cnt` and the partial remainder; go to RUN.
- **IDLE, `start`=0:** stay in IDLE.
- **RUN:**
  - Each cycle performs one restoring-division step on the current lane.
  - Lane index = `cnt` / lane width. Bit within lane = `cnt` mod lane width, processed MSB-first.
  - Partial remainder width is lane width + 1. At each lane boundary the remainder clears and the next lane starts.
  - Lanes are processed in order lane 0 → last lane.
  - 8×8 = 4×16 = 2×32 = 1×64 = 64 steps, so RUN always lasts exactly 64 cycles.
  - At the end of each lane, write that lane's quotient or remainder into the result register.
  - When `cnt` = 63, go to DONE.
- **DONE:**
  - `result_valid` = 1 and `stall` = 0.
  - `start` is ignored, because the same instruction is still present until the upstream register advances on this edge.
  - Next state is always IDLE.
- **Divide by zero, per lane:**
  - Quotient = all ones for that lane width.
  - Remainder = that lane's dividend.
  - Other lanes are unaffected.
- Arithmetic is unsigned. No flags and no exceptions.
- `ppp` is not interpreted here; it is passed through for write-back masking.

## Timing
- `stall` = (IDLE & `start`) | RUN. It is combinational from the state register and `start`.
- **Latency**, with start seen in cycle 0:
  - `stall` is high in cycles 0–64 (65 cycles).
  - DONE and `result_valid` occur in cycle 65.
  - A new instruction can be accepted in cycle 66 at the earliest.
- `result`, `rd_out`, `ppp_out` and `ww_out` are registered. They hold their values after DONE until the next DONE.
- `ww` and operands are sampled only at the IDLE→RUN edge. Changes during RUN have no effect.
- **Reset**, including mid-RUN:
  - Next state is IDLE.
  - `stall`, `result_valid`, `result`, `rd_out`, `ppp_out`, `ww_out` and `cnt` are all 0.
  - Any in-flight operation is discarded.
  - Reset wins over a simultaneous `start`.

## Test plan
- **Single 64-bit lane:** `ww`=11, a=100, b=7, `op_mod`=0.
  - `stall` is high in cycles 0–64.
  - `result_valid` pulses in cycle 65 with `result`=14.
  - Repeating with `op_mod`=1 gives `result`=2.
- **Byte lanes:** `ww`=00, a=0xFFFF_FFFF_FFFF_FFFF, b=0x0202_0202_0202_0202.
  - Div gives 0x7F7F_7F7F_7F7F_7F7F.
  - Mod gives 0x0101_0101_0101_0101.
- **32-bit lanes:** `ww`=10, a=0xFFFF_FFFF_0000_0010, b=0x0000_0010_0000_0003.
  - Div gives 0x0FFF_FFFF_0000_0005.
  - Mod gives 0x0000_000F_0000_0001.
- **Divide by zero, 16-bit lanes:** `ww`=01, a=0x1234_5678_9ABC_DEF0, b=0x0001_0000_0002_0010.
  - Div gives 0x1234_FFFF_4D5E_0DEF.
  - Mod gives 0x0000_5678_0000_0000.
  - `rd_out` and `ppp_out` equal the values captured at start.
- **Held `start`:** keep `start` high through DONE, then drop it.
  - No second operation launches from DONE.
  - Raising `start` in cycle 66 launches a new operation, with `stall` high from cycle 66.
- **Reset mid-operation:** assert `reset` in cycle 30.
  - In cycle 31 all outputs are 0 and the unit is in IDLE.
  - A following start completes normally, producing a correct result 65 cycles later.

Source files
------------

// File: rtl/exmem_div_unit.sv
// exmem_div_unit: iterative unsigned lane-wise divide/modulo, one quotient bit per cycle.
// Revision 1.0 - initial release.
`default_nettype none

module exmem_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op_mod,
   input  logic [1:0]  ww,
   input  logic [0:63] a_data,
   input  logic [0:63] b_data,
   input  logic [4:0]  rd_in,
   input  logic [2:0]  ppp_in,
   output logic        stall,
   output logic [0:63] result,
   output logic        result_valid,
   output logic [4:0]  rd_out,
   output logic [2:0]  ppp_out,
   output logic [1:0]  ww_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [63:0] C_ONES = {64{1'b1}};

   state_t      state_q, state_d;
   logic [63:0] a_q, a_d;
   logic [63:0] b_q, b_d;
   logic        op_mod_q, op_mod_d;
   logic [1:0]  ww_q, ww_d;
   logic [4:0]  rd_q, rd_d;
   logic [2:0]  ppp_q, ppp_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] rem_q, rem_d;
   logic [63:0] quo_q, quo_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] result_q, result_d;
   logic [4:0]  rd_out_q, rd_out_d;
   logic [2:0]  ppp_out_q, ppp_out_d;
   logic [1:0]  ww_out_q, ww_out_d;

   logic [5:0]  w_wm1;
   logic [5:0]  w_j;
   logic        w_first;
   logic        w_last;
   logic [5:0]  w_shift;
   logic [63:0] w_mask;
   logic [63:0] w_div;
   logic [63:0] w_rem_in;
   logic [63:0] w_quo_in;
   logic [64:0] w_trial;
   logic        w_ge;
   logic [63:0] w_diff;
   logic [63:0] w_rem_next;
   logic [63:0] w_quo_next;
   logic [63:0] w_lane_val;
   logic [63:0] w_acc_next;

   always_comb begin
      w_wm1 = 6'd63;
      case (ww_q)
         2'b00:   w_wm1 = 6'd7;
         2'b01:   w_wm1 = 6'd15;
         2'b10:   w_wm1 = 6'd31;
         default: w_wm1 = 6'd63;
      endcase
   end

   // Lanes are packed MSB-first, so step cnt always consumes dividend bit 63-cnt;
   // the current lane's LSB sits at (63-cnt) rounded down to a lane boundary.
   assign w_j        = cnt_q & w_wm1;
   assign w_first    = (w_j == 6'd0);
   assign w_last     = (w_j == w_wm1);
   assign w_shift    = ~cnt_q & ~w_wm1;
   assign w_mask     = C_ONES >> (~w_wm1);
   assign w_div      = (b_q >> w_shift) & w_mask;
   assign w_rem_in   = w_first ? 64'd0 : rem_q;
   assign w_quo_in   = w_first ? 64'd0 : quo_q;
   assign w_trial    = {w_rem_in, a_q[~cnt_q]};
   assign w_ge       = (w_trial >= {1'b0, w_div});
   assign w_diff     = w_trial[63:0] - w_div;
   assign w_rem_next = w_ge ? w_diff : w_trial[63:0];
   assign w_quo_next = (w_quo_in << 1) | {63'd0, w_ge};
   assign w_lane_val = (op_mod_q ? w_rem_next : w_quo_next) & w_mask;
   assign w_acc_next = (acc_q & ~(w_mask << w_shift)) | (w_lane_val << w_shift);

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      op_mod_d     = op_mod_q;
      ww_d         = ww_q;
      rd_d         = rd_q;
      ppp_d        = ppp_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      acc_d        = acc_q;
      result_d     = result_q;
      rd_out_d     = rd_out_q;
      ppp_out_d    = ppp_out_q;
      ww_out_d     = ww_out_q;
      stall        = 1'b0;
      result_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               stall    = 1'b1;
               a_d      = a_data;
               b_d      = b_data;
               op_mod_d = op_mod;
               ww_d     = ww;
               rd_d     = rd_in;
               ppp_d    = ppp_in;
               cnt_d    = 6'd0;
               rem_d    = 64'd0;
               quo_d    = 64'd0;
               acc_d    = 64'd0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            stall = 1'b1;
            cnt_d = cnt_q + 6'd1;
            rem_d = w_rem_next;
            quo_d = w_quo_next;
            if (w_last) begin
               acc_d = w_acc_next;
            end
            if (cnt_q == 6'd63) begin
               result_d  = w_acc_next;
               rd_out_d  = rd_q;
               ppp_out_d = ppp_q;
               ww_out_d  = ww_q;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            // The issuing instruction is still held upstream this cycle, so start is ignored.
            result_valid = 1'b1;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a_q       <= 64'd0;
         b_q       <= 64'd0;
         op_mod_q  <= 1'b0;
         ww_q      <= 2'd0;
         rd_q      <= 5'd0;
         ppp_q     <= 3'd0;
         cnt_q     <= 6'd0;
         rem_q     <= 64'd0;
         quo_q     <= 64'd0;
         acc_q     <= 64'd0;
         result_q  <= 64'd0;
         rd_out_q  <= 5'd0;
         ppp_out_q <= 3'd0;
         ww_out_q  <= 2'd0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_mod_q  <= op_mod_d;
         ww_q      <= ww_d;
         rd_q      <= rd_d;
         ppp_q     <= ppp_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         rd_out_q  <= rd_out_d;
         ppp_out_q <= ppp_out_d;
         ww_out_q  <= ww_out_d;
      end
   end

   assign result  = result_q;
   assign rd_out  = rd_out_q;
   assign ppp_out = ppp_out_q;
   assign ww_out  = ww_out_q;

endmodule

`default_nettype wire

// File: tb/tb_exmem_div_unit.sv
// tb_exmem_div_unit: directed and randomized checks of exmem_div_unit against a lane-arithmetic model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_exmem_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        op_mod;
   logic [1:0]  ww;
   logic [0:63] a_data;
   logic [0:63] b_data;
   logic [4:0]  rd_in;
   logic [2:0]  ppp_in;
   logic        stall;
   logic [0:63] result;
   logic        result_valid;
   logic [4:0]  rd_out;
   logic [2:0]  ppp_out;
   logic [1:0]  ww_out;

   int n_cmp = 0;
   int n_bad = 0;

   exmem_div_unit dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .op_mod       (op_mod),
      .ww           (ww),
      .a_data       (a_data),
      .b_data       (b_data),
      .rd_in        (rd_in),
      .ppp_in       (ppp_in),
      .stall        (stall),
      .result       (result),
      .result_valid (result_valid),
      .rd_out       (rd_out),
      .ppp_out      (ppp_out),
      .ww_out       (ww_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain per-lane division; lane 0 is the most significant lane.
   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] w, input logic op);
      int          lw;
      int          pos;
      logic [63:0] mask;
      logic [63:0] av;
      logic [63:0] bv;
      logic [63:0] r;
      logic [63:0] res;
      lw   = 8 << w;
      mask = {64{1'b1}} >> (64 - lw);
      res  = 64'd0;
      for (int l = 0; l < 64 / lw; l++) begin
         pos = 64 - (l + 1) * lw;
         av  = (a >> pos) & mask;
         bv  = (b >> pos) & mask;
         if (bv == 64'd0) r = op ? av : mask;
         else             r = op ? (av % bv) : (av / bv);
         res = res | (r << pos);
      end
      return res;
   endfunction

   task automatic randomize_inputs();
      a_data = {$urandom, $urandom};
      b_data = {$urandom, $urandom};
      ww     = 2'($urandom_range(0, 3));
      op_mod = 1'($urandom_range(0, 1));
      rd_in  = 5'($urandom);
      ppp_in = 3'($urandom);
   endtask

   // Called just after a posedge (cycle 0); returns just after the posedge of cycle 66.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] w, input logic op, input logic [4:0] rd,
                         input logic [2:0] ppp, input logic [63:0] exp, input bit hold);
      int bad_stall = 0;
      int bad_valid = 0;
      start  = 1'b1;
      a_data = a;
      b_data = b;
      ww     = w;
      op_mod = op;
      rd_in  = rd;
      ppp_in = ppp;
      @(negedge clk);
      if (stall !== 1'b1) bad_stall++;
      for (int c = 1; c <= 64; c++) begin
         @(posedge clk);
         #1;
         if (!hold) start = 1'b0;
         randomize_inputs();
         @(negedge clk);
         if (stall !== 1'b1) bad_stall++;
         if (result_valid !== 1'b0) bad_valid++;
      end
      @(posedge clk);
      #1;
      randomize_inputs();
      @(negedge clk);
      check_eq({tag, "_stall_0_64"}, 64'(bad_stall), 64'd0);
      check_eq({tag, "_early_valid"}, 64'(bad_valid), 64'd0);
      check_eq({tag, "_valid_c65"}, 64'(result_valid), 64'd1);
      check_eq({tag, "_stall_c65"}, 64'(stall), 64'd0);
      check_eq({tag, "_result"}, result, exp);
      check_eq({tag, "_rd_out"}, 64'(rd_out), 64'(rd));
      check_eq({tag, "_ppp_out"}, 64'(ppp_out), 64'(ppp));
      check_eq({tag, "_ww_out"}, 64'(ww_out), 64'(w));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_stall"}, 64'(stall), 64'd0);
      check_eq({tag, "_valid"}, 64'(result_valid), 64'd0);
      check_eq({tag, "_result"}, result, 64'd0);
      check_eq({tag, "_fields"}, {54'd0, rd_out, ppp_out, ww_out}, 64'd0);
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic [63:0] mask;
      logic [63:0] lane;
      logic [1:0]  rw;
      logic        rop;
      int          lw;
      int          pos;

      reset  = 1'b1;
      start  = 1'b0;
      op_mod = 1'b0;
      ww     = 2'd0;
      a_data = 64'd0;
      b_data = 64'd0;
      rd_in  = 5'd0;
      ppp_in = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_op("w64_div", 64'd100, 64'd7, 2'b11, 1'b0, 5'd3, 3'd5, 64'd14, 1'b0);
      run_op("w64_mod", 64'd100, 64'd7, 2'b11, 1'b1, 5'd4, 3'd6, 64'd2, 1'b0);
      run_op("w8_div", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0202_0202_0202_0202, 2'b00, 1'b0,
             5'd9, 3'd1, 64'h7F7F_7F7F_7F7F_7F7F, 1'b0);
      run_op("w8_mod", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0202_0202_0202_0202, 2'b00, 1'b1,
             5'd10, 3'd2, 64'h0101_0101_0101_0101, 1'b0);
      run_op("w32_div", 64'hFFFF_FFFF_0000_0010, 64'h0000_0010_0000_0003, 2'b10, 1'b0,
             5'd17, 3'd3, 64'h0FFF_FFFF_0000_0005, 1'b0);
      run_op("w32_mod", 64'hFFFF_FFFF_0000_0010, 64'h0000_0010_0000_0003, 2'b10, 1'b1,
             5'd18, 3'd4, 64'h0000_000F_0000_0001, 1'b0);
      run_op("dz16_div", 64'h1234_5678_9ABC_DEF0, 64'h0001_0000_0002_0010, 2'b01, 1'b0,
             5'd31, 3'd7, 64'h1234_FFFF_4D5E_0DEF, 1'b0);
      run_op("dz16_mod", 64'h1234_5678_9ABC_DEF0, 64'h0001_0000_0002_0010, 2'b01, 1'b1,
             5'd21, 3'd2, 64'h0000_5678_0000_0000, 1'b0);

      // Start held through DONE must not relaunch; outputs hold after DONE.
      run_op("hold", 64'd1000, 64'd33, 2'b11, 1'b0, 5'd12, 3'd5, 64'd30, 1'b1);
      @(negedge clk);
      check_eq("hold_no_relaunch", 64'(stall), 64'd0);
      check_eq("hold_no_valid", 64'(result_valid), 64'd0);
      check_eq("hold_result_kept", result, 64'd30);
      @(posedge clk);
      #1;

      // Reset asserted in cycle 30 of an operation.
      start  = 1'b1;
      a_data = 64'hDEAD_BEEF_0000_0001;
      b_data = 64'h0000_0003_0000_0005;
      ww     = 2'b10;
      op_mod = 1'b0;
      rd_in  = 5'd7;
      ppp_in = 3'd3;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_outputs_zero("midrst");
      @(posedge clk);
      #1;
      run_op("after_rst", 64'hDEAD_BEEF_0000_0001, 64'h0000_0003_0000_0005, 2'b10, 1'b1,
             5'd8, 3'd1, model(64'hDEAD_BEEF_0000_0001, 64'h0000_0003_0000_0005, 2'b10, 1'b1),
             1'b0);

      // Randomized: per-lane divisors of random magnitude, some zero.
      for (int t = 0; t < 24; t++) begin
         rw   = 2'($urandom_range(0, 3));
         rop  = 1'($urandom_range(0, 1));
         ra   = {$urandom, $urandom};
         rb   = 64'd0;
         lw   = 8 << rw;
         mask = {64{1'b1}} >> (64 - lw);
         for (int l = 0; l < 64 / lw; l++) begin
            pos  = 64 - (l + 1) * lw;
            lane = {$urandom, $urandom};
            lane = lane & (mask >> $urandom_range(0, lw - 1));
            if ($urandom_range(0, 4) == 0) lane = 64'd0;
            rb = rb | (lane << pos);
         end
         run_op($sformatf("rnd%0d", t), ra, rb, rw, rop, 5'($urandom), 3'($urandom),
                model(ra, rb, rw, rop), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
